// File: rtl/sum_bcd_pkg.sv
// Shared types and constants for the sum-to-BCD seven-segment display block.
// Glyphs are encoded {g,f,e,d,c,b,a}, active high.
package sum_bcd_pkg;

   localparam int unsigned SUM_W     = 5;
   localparam int unsigned BCD_W     = 8;
   localparam int unsigned NUM_STEPS = 5;

   typedef enum logic {
      StIdle,
      StConv
   } state_e;

   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   // Double-dabble correction applied to one BCD nibble before each shift.
   function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
      return (nib >= 4'd5) ? nib + 4'd3 : nib;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to seven-segment glyph lookup; values above 9 are blank.
module seg7_decode
   import sum_bcd_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (digit_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/sum_bcd_display.sv
// Converts a 5-bit sum to two BCD digits by serial double-dabble and multiplexes them onto
// a two-digit seven-segment display. Define SUM_BCD_DISPLAY_ZERO_BLANK_EN to blank a zero tens.
module sum_bcd_display
   import sum_bcd_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic [SUM_W-1:0] sum_in,
   input  logic             sum_valid,
   output logic             sum_ready,
   output logic [6:0]       seg,
   output logic [1:0]       dig_sel,
   output logic             busy
);

   localparam int unsigned CntW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned StepW = $clog2(NUM_STEPS);

   state_e             state_q, state_d;
   logic [SUM_W-1:0]   shift_q, shift_d;
   logic [BCD_W-1:0]   scratch_q, scratch_d;
   logic [StepW-1:0]   step_q, step_d;
   logic [3:0]         tens_q, tens_d;
   logic [3:0]         ones_q, ones_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic               idx_q, idx_d;

   logic [BCD_W-1:0]   adj;
   logic [BCD_W-1:0]   stepped;
   logic [3:0]         digit;
   logic [6:0]         glyph;

   assign adj     = {dabble_adj(scratch_q[7:4]), dabble_adj(scratch_q[3:0])};
   // The adjusted scratch never exceeds 7 bits here, so dropping the top bit is lossless.
   assign stepped = BCD_W'({adj, shift_q[SUM_W-1]});

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      scratch_d = scratch_q;
      step_d    = step_q;
      tens_d    = tens_q;
      ones_d    = ones_q;
      if (ena) begin
         unique case (state_q)
            StIdle: begin
               if (sum_valid) begin
                  shift_d   = sum_in;
                  scratch_d = '0;
                  step_d    = '0;
                  state_d   = StConv;
               end
            end
            StConv: begin
               scratch_d = stepped;
               shift_d   = {shift_q[SUM_W-2:0], 1'b0};
               step_d    = step_q + StepW'(1);
               if (step_q == StepW'(NUM_STEPS - 1)) begin
                  tens_d  = stepped[7:4];
                  ones_d  = stepped[3:0];
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      idx_d = idx_q;
      if (ena) begin
         if (cnt_q == CntW'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            idx_d = ~idx_q;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         shift_q   <= '0;
         scratch_q <= '0;
         step_q    <= '0;
         tens_q    <= '0;
         ones_q    <= '0;
         cnt_q     <= '0;
         idx_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         scratch_q <= scratch_d;
         step_q    <= step_d;
         tens_q    <= tens_d;
         ones_q    <= ones_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
      end
   end

   assign sum_ready = ena && (state_q == StIdle);
   assign busy      = (state_q == StConv);
   assign dig_sel   = idx_q ? 2'b10 : 2'b01;
   assign digit     = idx_q ? tens_q : ones_q;

   seg7_decode u_seg7_decode (
      .digit_i (digit),
      .seg_o   (glyph)
   );

`ifdef SUM_BCD_DISPLAY_ZERO_BLANK_EN
   assign seg = (idx_q && (tens_q == 4'd0)) ? SEG_BLANK : glyph;
`else
   assign seg = glyph;
`endif

endmodule

// File: tb/tb_sum_bcd_display.sv
// Self-checking bench for sum_bcd_display: table vectors, directed corner sequences and
// randomized traffic checked every cycle against a decimal-arithmetic reference model.
module tb_sum_bcd_display;

   localparam int unsigned DIV = 4;

`ifdef SUM_BCD_DISPLAY_ZERO_BLANK_EN
   localparam logic [6:0] TENS_ZERO = 7'b0000000;
`else
   localparam logic [6:0] TENS_ZERO = 7'b0111111;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ena = 1'b0;
   logic [4:0] sum_in = '0;
   logic       sum_valid = 1'b0;
   logic       sum_ready;
   logic [6:0] seg;
   logic [1:0] dig_sel;
   logic       busy;

   sum_bcd_display #(
      .REFRESH_DIV (DIV)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .sum_in    (sum_in),
      .sum_valid (sum_valid),
      .sum_ready (sum_ready),
      .seg       (seg),
      .dig_sel   (dig_sel),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: conversion countdown, pending value, decimal digits, enabled-cycle count.
   int m_busy  = 0;
   int m_pend  = 0;
   int m_tens  = 0;
   int m_ones  = 0;
   int m_ticks = 0;

   logic [6:0] glyph_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                  7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

   typedef struct {
      logic [4:0] value;
      logic [6:0] tens_seg;
      logic [6:0] ones_seg;
   } vec_t;

   vec_t tab [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [6:0] exp_seg();
      int idx;
      idx = (m_ticks / DIV) % 2;
`ifdef SUM_BCD_DISPLAY_ZERO_BLANK_EN
      if (idx == 1 && m_tens == 0) return 7'b0000000;
`endif
      return (idx == 1) ? glyph_tab[m_tens] : glyph_tab[m_ones];
   endfunction

   task automatic model_step();
      if (rst) begin
         m_busy  = 0;
         m_tens  = 0;
         m_ones  = 0;
         m_ticks = 0;
      end else if (ena) begin
         if (m_busy == 0) begin
            if (sum_valid) begin
               m_pend = int'(sum_in);
               m_busy = 5;
            end
         end else begin
            m_busy--;
            if (m_busy == 0) begin
               m_tens = m_pend / 10;
               m_ones = m_pend % 10;
            end
         end
         m_ticks++;
      end
   endtask

   task automatic cycle(input logic r, input logic e, input logic v, input logic [4:0] s);
      @(negedge clk);
      rst = r; ena = e; sum_valid = v; sum_in = s;
      @(posedge clk);
      model_step();
      #1;
      check("model_ready", 32'(sum_ready), 32'((m_busy == 0) && ena));
      check("model_busy", 32'(busy), 32'(m_busy != 0));
      check("model_dig_sel", 32'(dig_sel), ((m_ticks / DIV) % 2 == 1) ? 32'd2 : 32'd1);
      check("model_seg", 32'(seg), 32'(exp_seg()));
   endtask

   task automatic wait_idle();
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (sum_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         cycle(1'b0, 1'b1, 1'b0, 5'd0);
      end
      check("idle_wait", 32'(ok), 32'd1);
   endtask

   task automatic show_check(input string name, input logic [6:0] t_seg, input logic [6:0] o_seg);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 5'd0);
         if (dig_sel == 2'b10) begin
            ok = 1'b1;
            break;
         end
      end
      check({name, "_tens_seg"}, ok ? 32'(seg) : 32'hdead, 32'(t_seg));
      ok = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 5'd0);
         if (dig_sel == 2'b01) begin
            ok = 1'b1;
            break;
         end
      end
      check({name, "_ones_seg"}, ok ? 32'(seg) : 32'hdead, 32'(o_seg));
   endtask

   initial begin
      int busy_n;
      int vi;
      logic [4:0] seq [3];

      tab[0]  = '{5'd13, 7'b0000110, 7'b1001111};
      tab[1]  = '{5'd30, 7'b1001111, 7'b0111111};
      tab[2]  = '{5'd31, 7'b1001111, 7'b0000110};
      tab[3]  = '{5'd0,  TENS_ZERO,  7'b0111111};
      tab[4]  = '{5'd7,  TENS_ZERO,  7'b0000111};
      tab[5]  = '{5'd9,  TENS_ZERO,  7'b1101111};
      tab[6]  = '{5'd10, 7'b0000110, 7'b0111111};
      tab[7]  = '{5'd19, 7'b0000110, 7'b1101111};
      tab[8]  = '{5'd25, 7'b1011011, 7'b1101101};
      tab[9]  = '{5'd28, 7'b1011011, 7'b1111111};
      tab[10] = '{5'd16, 7'b0000110, 7'b1111101};
      tab[11] = '{5'd24, 7'b1011011, 7'b1100110};

      // Reset state
      cycle(1'b1, 1'b1, 1'b0, 5'd0);
      cycle(1'b1, 1'b1, 1'b1, 5'd9);
      check("rst_ready", 32'(sum_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_dig_sel", 32'(dig_sel), 32'd1);
      check("rst_seg", 32'(seg), 32'h3f);

      // 13: busy for exactly 5 sampled cycles, then digits 1/3
      cycle(1'b0, 1'b1, 1'b1, 5'd13);
      busy_n = busy ? 1 : 0;
      for (int i = 0; i < 10 && busy; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 5'd0);
         if (busy) busy_n++;
      end
      check("busy_cycles", 32'(busy_n), 32'd5);
      check("ready_after_conv", 32'(sum_ready), 32'd1);
      show_check("sum13", 7'b0000110, 7'b1001111);

      // Table vectors
      foreach (tab[k]) begin
         wait_idle();
         cycle(1'b0, 1'b1, 1'b1, tab[k].value);
         wait_idle();
         show_check($sformatf("tab%0d", tab[k].value), tab[k].tens_seg, tab[k].ones_seg);
      end

      // Back-to-back 30, 31, 0 offered at every sum_ready
      wait_idle();
      seq[0] = 5'd30; seq[1] = 5'd31; seq[2] = 5'd0;
      vi = 0;
      for (int i = 0; i < 40 && vi < 3; i++) begin
         if (sum_ready) begin
            cycle(1'b0, 1'b1, 1'b1, seq[vi]);
            vi++;
         end else begin
            cycle(1'b0, 1'b1, 1'b1, 5'(($urandom % 31) + 1));
         end
      end
      check("b2b_offered", 32'(vi), 32'd3);
      wait_idle();
      show_check("b2b_last", TENS_ZERO, 7'b0111111);

      // sum_valid held high through CONV with changing data
      wait_idle();
      cycle(1'b0, 1'b1, 1'b1, 5'd22);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1, 5'($urandom % 32));
      cycle(1'b0, 1'b1, 1'b0, 5'd0);
      show_check("hold_valid", 7'b1011011, 7'b1011011);

      // Refresh slots of 4 cycles; 3 disabled cycles stretch the slot by 3
      cycle(1'b1, 1'b1, 1'b0, 5'd0);
      cycle(1'b0, 1'b1, 1'b0, 5'd0);
      check("slot_t1", 32'(dig_sel), 32'd1);
      cycle(1'b0, 1'b1, 1'b0, 5'd0);
      check("slot_t2", 32'(dig_sel), 32'd1);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b0, 1'b1, 5'd5);
         check("slot_frozen", 32'(dig_sel), 32'd1);
         check("ready_ena_low", 32'(sum_ready), 32'd0);
      end
      cycle(1'b0, 1'b1, 1'b0, 5'd0);
      check("slot_t3", 32'(dig_sel), 32'd1);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 5'd0);
         check("slot_tens", 32'(dig_sel), 32'd2);
      end
      cycle(1'b0, 1'b1, 1'b0, 5'd0);
      check("slot_wrap", 32'(dig_sel), 32'd1);

      // Reset on the 3rd CONV cycle aborts and clears digits
      wait_idle();
      cycle(1'b0, 1'b1, 1'b1, 5'd13);
      wait_idle();
      cycle(1'b0, 1'b1, 1'b1, 5'd25);
      cycle(1'b0, 1'b1, 1'b0, 5'd0);
      cycle(1'b1, 1'b1, 1'b0, 5'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_ready", 32'(sum_ready), 32'd1);
      check("abort_dig_sel", 32'(dig_sel), 32'd1);
      check("abort_ones", 32'(seg), 32'h3f);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 5'd0);
      check("abort_tens_slot", 32'(dig_sel), 32'd2);
      check("abort_tens", 32'(seg), 32'(TENS_ZERO));

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         cycle(($urandom % 100) == 0, ($urandom % 8) != 0, 1'($urandom % 2), 5'($urandom % 32));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sum_bcd_display.md
SUM_BCD_DISPLAY -- requirements
Module: sum_bcd_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 1024, giving the clk cycles per digit-multiplex slot (legal range 2..65536).
REQ-002 SHALL have input clk, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have input rst, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have input ena, 1 bit: design enable; low freezes all internal state.
REQ-005 SHALL have input sum_in, 5 bits: unsigned sum from the 4-bit adder stage, range 0..31.
REQ-006 SHALL have input sum_valid, 1 bit: sum_in is valid this cycle.
REQ-007 SHALL have output sum_ready, 1 bit: block can accept a new sum this cycle.
REQ-008 SHALL have output seg, 7 bits: active-high segments, seg[0]=a through seg[6]=g.
REQ-009 SHALL have output dig_sel, 2 bits: one-hot active-high digit enable, bit0=ones, bit1=tens.
REQ-010 SHALL have output busy, 1 bit: high while a conversion is in progress.

Function
REQ-011 SHALL use FSM states IDLE and CONV.
REQ-012 SHALL drive sum_ready=1 exactly when state=IDLE and ena=1.
REQ-013 SHALL define a transfer as sum_valid=1 and sum_ready=1 on the same edge; the transfer captures sum_in into a 5-bit shift register, clears an 8-bit BCD scratch register and moves to CONV.
REQ-014 SHALL perform in CONV one double-dabble step per enabled cycle for 5 cycles: add 3 to any scratch nibble >=5, then shift left one bit, taking the MSB of the shift register into scratch bit 0.
REQ-015 SHALL, on the edge completing the 5th step, copy the scratch register to the displayed tens/ones registers and return to IDLE; sum_ready is high again on the next cycle.
REQ-016 SHALL give a latency of 6 edges from transfer to the displayed registers updating.
REQ-017 SHALL ignore sum_valid while in CONV, with no queuing.
REQ-018 SHALL keep displayed digits unchanged during CONV; they hold the previous result until the update.
REQ-019 SHALL drive busy=1 exactly when state=CONV.
REQ-020 SHALL convert every 5-bit input exactly, e.g. 30 gives tens=3, ones=0 and 31 gives tens=3, ones=1.
REQ-021 SHALL count a refresh counter 0..REFRESH_DIV-1 while ena=1, wrapping to 0 and toggling the digit index at each wrap.
REQ-022 SHALL drive dig_sel=01 and seg=decode(ones) when index=0, and dig_sel=10 and seg=decode(tens) when index=1; dig_sel is never 00 or 11 while ena=1.
REQ-023 SHALL use standard 0-9 glyphs for the decode, e.g. 0 gives 0111111, 1 gives 0000110, 3 gives 1001111; nibble values >9 give 0000000.
REQ-024 SHALL, with ena=0, hold FSM, counter and index, force sum_ready=0, and hold seg/dig_sel at their last values.

Reset
REQ-025 SHALL, on rst=1, set state=IDLE, clear the shift and scratch registers, set tens=0, ones=0, refresh counter=0 and index=0.
REQ-026 SHALL give the following output values during and after reset: sum_ready=ena, busy=0, dig_sel=01, seg=0111111.
REQ-027 SHALL give rst priority over ena and over any transfer; rst during CONV aborts the conversion and the displayed digits read 00.

Configuration
REQ-028 SHALL use the macro SUM_BCD_DISPLAY_ZERO_BLANK_EN to enable leading-zero blanking.
REQ-029 SHALL, with the macro defined, drive seg=0000000 during the tens slot when tens=0, while dig_sel still follows REQ-022.
REQ-030 SHALL, without the macro, display tens=0 as glyph 0.

Structure
REQ-031 SHALL place the following in shared package sum_bcd_pkg: the FSM state enum, SUM_W=5, BCD_W=8, the step count 5, and the seven-segment glyph constants for 0-9 and blank.
REQ-032 SHALL implement the nibble-to-segment lookup as one combinational sub-module, seg7_decode, instantiated once after the digit mux.

Verification
REQ-033 SHALL cover: reset, then transfer sum_in=13 -> busy high for 5 cycles, sum_ready low for those cycles, digits 1/3 from cycle 6; tens slot seg=0000110, ones slot seg=1001111.
REQ-034 SHALL cover: transfer 30, then 31, then 0 back-to-back at each sum_ready -> digits 3/0, 3/1, 0/0; no transfer lost or duplicated.
REQ-035 SHALL cover: sum_valid held high throughout CONV with changing sum_in -> only the value at the accepting edge is displayed.
REQ-036 SHALL cover: with REFRESH_DIV=4 -> dig_sel alternates 01/10 every 4 cycles; ena low for 3 cycles stretches the current slot by exactly 3 cycles.
REQ-037 SHALL cover: rst asserted on the 3rd CONV cycle -> next cycle state=IDLE, busy=0, digits 0/0, counter=0.
REQ-038 SHALL cover: sum 7 with the macro defined -> tens slot seg=0000000; without the macro -> 0111111.
